uart_rx_frame: RTL
==================

# uart_rx_frame

Receive-side framer for the UART: it synchronises the serial input `rxd`, detects and qualifies the start bit, and drives `rx_br_en` to the baud-rate generator. It then samples 8 data bits (LSB first) and one stop bit on each `rx_br_stb`. Completed bytes go to the host side through a valid/ready register, with framing-error and overrun flags. It sits directly downstream of the baud-rate generator's RX strobe and upstream of the host/FIFO logic.

## Interface
- `HALF_BIT`, 521: cycles from the detected start edge to the mid-start-bit sample. This is half of the 1043-cycle bit period at 10 MHz / 9600 bps.
- `CNT_W`, 10: half-bit counter width. Must satisfy 2^CNT_W > HALF_BIT.
- `clk`  in  1  system clock, 10 MHz; the only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `rxd`  in  1  serial line, asynchronous; idles high.
- `rx_br_stb`  in  1  one-cycle bit strobe from the baud-rate generator. It occurs 1043 cycles after `rx_br_en` rises, then every 1043 cycles.
- `rx_br_en`  out  1  enable for the generator's RX counter. Low holds that counter at 0.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  host accepts the byte; a transfer occurs when `rx_valid && rx_ready`.
- `rx_frm_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `rx_ovr_err`  out  1  one-cycle pulse: a byte completed while the previous byte was unconsumed.

## Operation
- **Input path:** `rxd` passes through a 2-FF synchroniser to give `rxd_s`, then one delay FF gives `rxd_d`. All three reset to 1. Falling edge is defined as `rxd_d==1 && rxd_s==0`.
- **State machine:** IDLE, START, DATA, STOP.
- **IDLE:** on a falling edge, clear the half counter and go to START. `rx_br_stb` is ignored in this state.
- **START:** increment the half counter each cycle. When it reaches `HALF_BIT-1`, sample `rxd_s`:
  - 0: go to DATA and clear the bit index.
  - 1: false start; go back to IDLE.
- **DATA:** on each `rx_br_stb`, shift `rxd_s` into bit [7] of the shift register, moving right so bits arrive LSB first, and increment the 3-bit index. On the strobe with index 7, go to STOP.
- **STOP:** on `rx_br_stb`:
  - `rxd_s==1`: load `rx_data`, set `rx_valid`, and pulse `rx_ovr_err` if `rx_valid` was high and `rx_ready` low that cycle.
  - `rxd_s==0`: pulse `rx_frm_err`. `rx_data` and `rx_valid` are unchanged.
  - In both cases, go to IDLE.
- **`rx_br_en`:** registered; 1 exactly while in DATA or STOP.
- **`rx_valid`:** clears on `rx_valid && rx_ready`. If a completion and a transfer happen in the same cycle, the new byte loads, `rx_valid` stays 1 and there is no overrun.
- **After a frame error:** a line held low (break) does not retrigger, because a fresh high-to-low edge is required.
- **Reset:**
  - Reset values: state IDLE, `rx_br_en` 0, `rx_data` 0x00, `rx_valid` 0, `rx_frm_err` 0, `rx_ovr_err` 0, counters 0.
  - Reset mid-frame aborts the frame silently.

## Timing
- Falling edge on `rxd` to entry into START: 3 cycles (synchroniser plus edge register).
- START lasts `HALF_BIT` cycles. `rx_br_en` rises the cycle after the START sample.
- The first `rx_br_stb` therefore lands about mid-bit 0. Later samples fall mid-bit, 1043 cycles apart.
- The stop-bit strobe leads to `rx_valid`/`rx_frm_err` one cycle later (registered).
- `rx_br_en` falls in that same cycle, resetting the generator's counter.
- A new start edge is accepted from the first IDLE cycle, so back-to-back frames with a single stop bit are supported.
- `rx_frm_err` and `rx_ovr_err` are high for exactly one cycle each.

## Structure
- Shared package `uart_pkg`:
  - `DATA_BITS`=8, `BR_THR`=1042, `HALF_BIT`=521.
  - RX state encoding: IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module `sync_2ff` (1-bit, reset value parameter) for the `rxd` synchroniser; reused later by the TX/CTS path.
- The remaining FSM, counters and output register live in `uart_rx_frame`.

## Test plan
- **Single byte:** frame 0x55, bit period 1043, stop=1, `rx_ready`=1 → one `rx_valid` cycle with `rx_data`=0x55. No error pulses. `rx_br_en` high for 9×1043 cycles ±1.
- **Glitch rejection:** `rxd` low for 200 cycles, then high → FSM returns to IDLE. `rx_br_en` never rises, `rx_valid` stays 0.
- **Framing error:** frame 0xA3 with stop=0 → `rx_frm_err` pulses once, `rx_valid` stays 0. A following good frame 0x3C yields `rx_data`=0x3C.
- **Overrun:** two back-to-back frames 0x11 then 0x22 with `rx_ready`=0 → `rx_ovr_err` pulses at the second completion. `rx_data`=0x22, `rx_valid`=1.
- **Coincident transfer:** `rx_ready` pulsed in the same cycle the second byte completes → no overrun, and `rx_valid` stays 1 with 0x22.
- **Reset mid-frame:** `rst` asserted during bit 4 of 0xF0 → all outputs at reset values immediately. Line high then frame 0x81 → `rx_data`=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, baud timing constants and the
// receive state encoding used by the RX framer.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BR_THR    = 1042;
    localparam int HALF_BIT  = 521;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: qualifies the start bit by sampling mid-bit, enables
// the baud generator for the data and stop bits, shifts in 8 bits LSB first
// and hands completed bytes to the host through a valid/ready register with
// one-cycle framing-error and overrun pulses.
module uart_rx_frame #(
    parameter int HALF_BIT = uart_pkg::HALF_BIT,
    parameter int CNT_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_br_stb,
    output logic       rx_br_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frm_err,
    output logic       rx_ovr_err
);

    import uart_pkg::*;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t        state;
    logic             rxd_s;
    logic             rxd_d;
    logic             fall;
    logic [CNT_W-1:0] half_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rxd_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rxd_s)
    );

    // Delayed copy of the synchronised line for high-to-low edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_d <= 1'b1;
        end else begin
            rxd_d <= rxd_s;
        end
    end

    // A held-low line never looks like a new edge, so a break cannot retrigger.
    assign fall = rxd_d & ~rxd_s;

    // Frame state machine with registered enable, data, valid and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            half_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_frm_err <= 1'b0;
            rx_ovr_err <= 1'b0;
            rx_br_en   <= 1'b0;
        end else begin
            rx_frm_err <= 1'b0;
            rx_ovr_err <= 1'b0;

            // Host consumption; a same-cycle completion below overrides this.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        half_cnt <= '0;
                        state    <= RX_START;
                    end
                end

                RX_START: begin
                    if (half_cnt == HALF_LAST) begin
                        if (!rxd_s) begin
                            bit_idx  <= '0;
                            rx_br_en <= 1'b1;
                            state    <= RX_DATA;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (rx_br_stb) begin
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end
                    end
                end

                RX_STOP: begin
                    if (rx_br_stb) begin
                        if (rxd_s) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            rx_ovr_err <= rx_valid & ~rx_ready;
                        end else begin
                            rx_frm_err <= 1'b1;
                        end
                        rx_br_en <= 1'b0;
                        state    <= RX_IDLE;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
